demux4_stream: RTL and testbench

Registered 1-to-4 demultiplexer, the distribution counterpart of the 4:1 select path. Routes one input stream to one of four output channels chosen by a 2-bit select, with valid/ready handshakes on both sides. Each output channel has its own one-entry output register, so a stalled channel does not block traffic to the other three. Used where a single producer (e.g. a store/write-back path) fans out to four consumers.

---
 rtl/demux4_stream.sv | 84 ++++++++
 tb/tb_demux4_stream.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on both sides and one output register per channel.
// Optional per-channel delivery counters: define DEMUX_COUNT_EN.
module demux4_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_sel,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [3:0]              out_valid,
  input  logic [3:0]              out_ready,
  output logic [4*DATA_WIDTH-1:0] out_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [4*CNT_WIDTH-1:0]  out_count
`endif
);

  if (CNT_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_param
    $error("demux4_stream: widths must be positive");
  end

  logic [3:0]            valid_q;
  logic [DATA_WIDTH-1:0] data_q [4];

  // Only the addressed channel gates acceptance; in_valid never feeds in_ready.
  assign in_ready  = !valid_q[in_sel] || out_ready[in_sel];
  assign out_valid = valid_q;

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
    end
  end

  // A load on the same edge as a drain wins, keeping the channel full.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (in_valid && in_ready && (in_sel == 2'(i))) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= in_data;
        end else if (valid_q[i] && out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (valid_q[i] && out_ready[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_count = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      out_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Directed self-checking bench for demux4_stream (counter section active when DEMUX_COUNT_EN is defined).
module tb_demux4_stream;

`ifdef DEMUX_COUNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*DW-1:0] out_data;
`ifdef DEMUX_COUNT_EN
  logic [4*CW-1:0] out_count;
`endif

  int vectors = 0;
  int errors  = 0;

  demux4_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] slice(input int unsigned ch);
    return out_data[ch*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_out_valid", out_valid, 4'b0000);
    chk("reset_out_data", out_data, '0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("reset_in_ready", in_ready, 1'b1);
    end

    // Single route to channel 2, held, then drained
    in_sel = 2'd2; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 32'h0;
    chk("route_valid", out_valid, 4'b0100);
    chk("route_data", slice(2), 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", out_valid, 4'b0100);
      chk("hold_data", slice(2), 32'hDEADBEEF);
    end
    #1;
    chk("hold_in_ready_sel2", in_ready, 1'b0);
    out_ready = 4'b0100;
    #1;
    chk("drain_in_ready_sel2", in_ready, 1'b1);
    step();
    out_ready = 4'b0000;
    chk("drain_valid", out_valid, 4'b0000);

    // Back-pressure on channel 1, other channel still accepts
    in_sel = 2'd1; in_data = 32'hAAAA0001; in_valid = 1'b1;
    step();
    in_data = 32'h55555555;
    #1;
    chk("bp_in_ready_sel1", in_ready, 1'b0);
    step();
    chk("bp_ch1_kept", slice(1), 32'hAAAA0001);
    in_sel = 2'd3; in_data = 32'h3;
    #1;
    chk("bp_in_ready_sel3", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_valid", out_valid, 4'b1010);
    chk("bp_ch3_data", slice(3), 32'h3);
    chk("bp_ch1_unchanged", slice(1), 32'hAAAA0001);

    // Drain channel 1 while channel 3 stays stalled
    out_ready = 4'b0010;
    step();
    chk("indep_valid", out_valid, 4'b1000);
    chk("indep_ch3", slice(3), 32'h3);

    // Streaming into a continuously ready channel 0
    out_ready = 4'b0001; in_sel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      in_data = DW'(k); in_valid = 1'b1;
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      step();
      chk("stream_valid0", out_valid[0], 1'b1);
      chk("stream_data0", slice(0), DW'(k));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", out_valid, 4'b1000);

    // Fill every channel, then reset with a competing input word
    out_ready = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      in_sel = 2'(s); in_data = DW'(32'h100 + s); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("full_valid", out_valid, 4'b1111);
    chk("full_ch1", slice(1), 32'h101);
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hFFFF_FFFF;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("midreset_valid", out_valid, 4'b0000);
    chk("midreset_data", out_data, '0);
    step();
    chk("midreset_dropped", out_valid, 4'b0000);

`ifdef DEMUX_COUNT_EN
    // 17 handshakes on channel 3 wrap a 4-bit counter to 1
    out_ready = 4'b1000; in_sel = 2'd3;
    for (int k = 0; k < 17; k++) begin
      in_data = DW'(k); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("count_ch3_wrap", out_count[3*CW +: CW], 4'd1);
    chk("count_others", out_count[3*CW-1:0], '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
